// File: rtl/adc_eth_capture_top_if.sv
// ---------------------------------------------------------------------------
// adc_eth_capture_top_if
// GMII transmit bundle driven by adc_eth_capture_top.
//   e_gtxc : transmit clock (forwarded system clock)
//   e_txen : transmit enable, high for every preamble/SFD/payload byte
//   e_txer : transmit error, held low
//   e_txd  : transmit data byte
// Modports: master = frame source (design), slave = frame sink (PHY / bench).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface adc_eth_capture_top_if;
    logic       e_gtxc;
    logic       e_txen;
    logic       e_txer;
    logic [7:0] e_txd;

    modport master (output e_gtxc, e_txen, e_txer, e_txd);
    modport slave  (input  e_gtxc, e_txen, e_txer, e_txd);
endinterface

// File: rtl/adc_eth_capture_top.sv
// ---------------------------------------------------------------------------
// adc_eth_capture_top
// Single-clock capture/stream top. A debounced key press clears the sample
// FIFO, records FRAME_BYTES ADC samples (one per adclk rising edge), then
// sends them as one GMII frame: 7 x 8'h55, 8'hD5, payload in write order,
// no FCS. temp_led toggles at the end of every frame.
//
// Build option: DAC_LOOPBACK_EN
//   defined   : dadata = addata captured on every adclk rising edge
//   undefined : dadata = free-running sawtooth, +1 per adclk rising edge
//
// Ports
//   clk                 : system clock, the only clock
//   rst_n               : asynchronous reset, ACTIVE HIGH despite the name
//   i_addata            : ADC sample byte
//   o_adclk / o_daclk   : ADC / DAC clock, clk/2
//   o_dadata            : DAC data
//   o_enADC             : high while recording
//   i_key_in            : start key, active high
//   o_temp_led          : toggles per completed frame
//   o_e_reset           : PHY reset_n, released one cycle after reset
//   o_e_mdc, io_e_mdio  : management pins, parked (0 / high-Z)
//   i_e_rxc             : ignored
//   gmii (master)       : e_gtxc / e_txen / e_txer / e_txd
//   o_enTx, o_overTx, o_enRe, o_overRe, o_beginSignal : phase flags/strobes
//   o_clk_32 (clk/4), o_clk_50, o_clk_100 (clk)
//   o_fifo_data_count, o_fifo_rst, o_key_state, o_current_state,
//   o_next_state, o_counter_for_rst, o_rst_flag, o_overRST : debug visibility
//
// State table
//   state        | meaning
//   0 S_IDLE     | wait for a debounced key press
//   1 S_FIFO_RST | hold FIFO cleared for RST_CYCLES cycles
//   2 S_RECORD   | write one sample per adclk rising edge until FRAME_BYTES
//   3 S_TX_PRE   | send preamble (7 x 55) and SFD (D5)
//   4 S_TX_DATA  | send one FIFO byte per clk until the FIFO is empty
//   5 S_DONE     | end of frame, toggle temp_led
// FIFO_DEPTH is expected to be a power of two (pointers wrap naturally).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_eth_capture_top #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RST_CYCLES      = 512,
    parameter int FIFO_DEPTH      = 1024,
    parameter int FRAME_BYTES     = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_addata,
    output logic                          o_daclk,
    output logic [7:0]                    o_dadata,
    output logic                          o_adclk,
    output logic                          o_enADC,
    input  logic                          i_key_in,
    output logic                          o_temp_led,
    output logic                          o_e_reset,
    output logic                          o_e_mdc,
    inout  wire                           io_e_mdio,
    input  logic                          i_e_rxc,
    adc_eth_capture_top_if.master         gmii,
    output logic                          o_enTx,
    output logic                          o_overTx,
    output logic                          o_enRe,
    output logic                          o_overRe,
    output logic                          o_beginSignal,
    output logic                          o_clk_32,
    output logic                          o_clk_50,
    output logic                          o_clk_100,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_data_count,
    output logic                          o_fifo_rst,
    output logic                          o_key_state,
    output logic [3:0]                    o_current_state,
    output logic [3:0]                    o_next_state,
    output logic [9:0]                    o_counter_for_rst,
    output logic                          o_rst_flag,
    output logic                          o_overRST
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BYTES);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [9:0]    RST_LAST  = 10'(RST_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FIFO_RST = 4'd1,
        S_RECORD   = 4'd2,
        S_TX_PRE   = 4'd3,
        S_TX_DATA  = 4'd4,
        S_DONE     = 4'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers / wires
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_next_state;

    logic            r_adclk;
    logic [1:0]      r_div;
    logic [7:0]      r_dadata;
    logic            r_e_reset;

    logic [DW-1:0]   r_deb_cnt;
    logic            r_key_state;
    logic            r_key_d;
    logic            w_begin;

    logic [9:0]      r_rst_cnt;
    logic [2:0]      r_pre_cnt;
    logic            r_temp_led;
    logic            r_txen;
    logic [7:0]      r_txd;
    logic            w_txen;
    logic [7:0]      w_txd;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [7:0]      w_fifo_head;

    logic            w_unused;

    assign w_unused = i_e_rxc;

    // ------------------------------------------------------------------
    // Clock outputs and dividers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_adclk   <= 1'b0;
            r_div     <= 2'd0;
            r_e_reset <= 1'b0;
        end else begin
            r_adclk   <= ~r_adclk;
            r_div     <= r_div + 2'd1;
            r_e_reset <= 1'b1;
        end
    end

    assign o_adclk   = r_adclk;
    assign o_daclk   = r_adclk;
    assign o_clk_32  = r_div[1];
    assign o_clk_50  = clk;
    assign o_clk_100 = clk;
    assign o_e_reset = r_e_reset;
    assign o_e_mdc   = 1'b0;
    assign io_e_mdio = 1'bz;

    // ------------------------------------------------------------------
    // DAC data; adclk rises on the edge where r_adclk is currently low
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_dadata <= 8'd0;
        end else if (!r_adclk) begin
`ifdef DAC_LOOPBACK_EN
            r_dadata <= i_addata;
`else
            r_dadata <= r_dadata + 8'd1;
`endif
        end
    end

    assign o_dadata = r_dadata;

    // ------------------------------------------------------------------
    // Key debounce: DEBOUNCE_CYCLES consecutive high samples set key_state,
    // the first low sample clears it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_deb_cnt   <= '0;
            r_key_state <= 1'b0;
            r_key_d     <= 1'b0;
        end else begin
            r_key_d <= r_key_state;
            if (!i_key_in) begin
                r_deb_cnt   <= '0;
                r_key_state <= 1'b0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_key_state <= 1'b1;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_begin       = r_key_state & ~r_key_d;
    assign o_key_state   = r_key_state;
    assign o_beginSignal = w_begin;

    // ------------------------------------------------------------------
    // Sample FIFO (first-word-fall-through head)
    // ------------------------------------------------------------------
    assign w_wr_en     = (r_state == S_RECORD) && !r_adclk &&
                         (r_count < FRAME_CNT) && (r_count < DEPTH_CNT);
    assign w_rd_en     = (r_state == S_TX_DATA) && (r_count != '0);
    assign w_fifo_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_addata;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (r_state == S_FIFO_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + 1'b1;
        end else if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
        end
    end

    assign o_fifo_data_count = r_count;

    // ------------------------------------------------------------------
    // Next-state decode and the byte presented to the GMII register stage
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_IDLE;
        w_txen       = 1'b0;
        w_txd        = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_next_state = w_begin ? S_FIFO_RST : S_IDLE;
            end
            S_FIFO_RST: begin
                w_next_state = (r_rst_cnt == RST_LAST) ? S_RECORD : S_FIFO_RST;
            end
            S_RECORD: begin
                w_next_state = (r_count >= FRAME_CNT) ? S_TX_PRE : S_RECORD;
            end
            S_TX_PRE: begin
                w_txen       = 1'b1;
                w_txd        = (r_pre_cnt == 3'd7) ? 8'hD5 : 8'h55;
                w_next_state = (r_pre_cnt == 3'd7) ? S_TX_DATA : S_TX_PRE;
            end
            S_TX_DATA: begin
                w_txen       = w_rd_en;
                w_txd        = w_rd_en ? w_fifo_head : 8'h00;
                // the byte read while count==1 is the last one
                w_next_state = (r_count <= CW'(1)) ? S_DONE : S_TX_DATA;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, phase timers and registered GMII outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_IDLE;
            r_rst_cnt  <= 10'd0;
            r_pre_cnt  <= 3'd0;
            r_temp_led <= 1'b0;
            r_txen     <= 1'b0;
            r_txd      <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_txen  <= w_txen;
            r_txd   <= w_txd;

            if ((r_state == S_FIFO_RST) && (r_rst_cnt != RST_LAST)) begin
                r_rst_cnt <= r_rst_cnt + 10'd1;
            end else begin
                r_rst_cnt <= 10'd0;
            end

            if (r_state == S_TX_PRE) begin
                r_pre_cnt <= r_pre_cnt + 3'd1;
            end else begin
                r_pre_cnt <= 3'd0;
            end

            if (r_state == S_DONE) begin
                r_temp_led <= ~r_temp_led;
            end
        end
    end

    assign o_current_state   = r_state;
    assign o_next_state      = w_next_state;
    assign o_counter_for_rst = r_rst_cnt;
    assign o_fifo_rst        = (r_state == S_FIFO_RST);
    assign o_rst_flag        = (r_state == S_FIFO_RST);
    assign o_overRST         = (r_state == S_FIFO_RST) && (r_rst_cnt == RST_LAST);
    assign o_enADC           = (r_state == S_RECORD);
    assign o_enRe            = (r_state == S_RECORD);
    assign o_overRe          = (r_state == S_RECORD) && (r_count >= FRAME_CNT);
    assign o_enTx            = (r_state == S_TX_PRE) || (r_state == S_TX_DATA);
    assign o_overTx          = (r_state == S_DONE);
    assign o_temp_led        = r_temp_led;

    assign gmii.e_gtxc = clk;
    assign gmii.e_txen = r_txen;
    assign gmii.e_txer = 1'b0;
    assign gmii.e_txd  = r_txd;

endmodule

// File: tb/tb_adc_eth_capture_top.sv
`timescale 1ns/1ps

module tb_adc_eth_capture_top;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [7:0]  addata = 8'h08;
    logic        key_in = 1'b0;
    logic        e_rxc  = 1'b0;
    wire         mdio;

    logic        daclk, adclk, enADC, temp_led, e_reset, e_mdc;
    logic [7:0]  dadata;
    logic        enTx, overTx, enRe, overRe, beginSignal;
    logic        clk_32, clk_50, clk_100;
    logic [10:0] fifo_data_count;
    logic        fifo_rst, key_state, rst_flag, overRST;
    logic [3:0]  current_state, next_state;
    logic [9:0]  counter_for_rst;

    adc_eth_capture_top_if gmii();

    adc_eth_capture_top dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_addata          (addata),
        .o_daclk           (daclk),
        .o_dadata          (dadata),
        .o_adclk           (adclk),
        .o_enADC           (enADC),
        .i_key_in          (key_in),
        .o_temp_led        (temp_led),
        .o_e_reset         (e_reset),
        .o_e_mdc           (e_mdc),
        .io_e_mdio         (mdio),
        .i_e_rxc           (e_rxc),
        .gmii              (gmii),
        .o_enTx            (enTx),
        .o_overTx          (overTx),
        .o_enRe            (enRe),
        .o_overRe          (overRe),
        .o_beginSignal     (beginSignal),
        .o_clk_32          (clk_32),
        .o_clk_50          (clk_50),
        .o_clk_100         (clk_100),
        .o_fifo_data_count (fifo_data_count),
        .o_fifo_rst        (fifo_rst),
        .o_key_state       (key_state),
        .o_current_state   (current_state),
        .o_next_state      (next_state),
        .o_counter_for_rst (counter_for_rst),
        .o_rst_flag        (rst_flag),
        .o_overRST         (overRST)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    int n_begin = 0, n_ovrst = 0, n_ovre = 0, n_ovtx = 0, n_fiforst = 0;
    int max_rst_cnt = 0;
    int tx_len = 0;
    int frames_done = 0;
    logic txen_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (current_state == s) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: state %0d not reached in %0d cycles (state %0d)", name, s, budget, current_state);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 1024; i++) exp_q.push_back(d);
    endtask

    task automatic press(input int cycles);
        @(negedge clk);
        key_in = 1'b1;
        repeat (cycles) @(negedge clk);
        key_in = 1'b0;
    endtask

    // Monitor: pulse counters plus frame scoreboard
    always @(negedge clk) begin
        if (beginSignal) n_begin++;
        if (overRST)     n_ovrst++;
        if (overRe)      n_ovre++;
        if (overTx)      n_ovtx++;
        if (fifo_rst)    n_fiforst++;
        if (int'(counter_for_rst) > max_rst_cnt) max_rst_cnt = int'(counter_for_rst);
        if (gmii.e_txen) begin
            tx_len++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_byte: got %0h expected nothing (no frame queued)", gmii.e_txd);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", {24'd0, gmii.e_txd}, {24'd0, mon_exp});
            end
        end else if (txen_d) begin
            check("tx_len", tx_len, 1032);
            tx_len = 0;
            frames_done++;
        end
        txen_d = gmii.e_txen;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int b0, r0, f0, e0, t0;

    initial begin
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // reset values
        check("rst_state",    current_state, 0);
        check("rst_count",    fifo_data_count, 0);
        check("rst_temp_led", temp_led, 0);
        check("rst_txd",      gmii.e_txd, 0);
        check("rst_txen",     gmii.e_txen, 0);
        check("rst_e_reset",  e_reset, 0);
        check("rst_adclk",    adclk, 0);

        rst_n = 1'b0;
        @(negedge clk);
        check("e_reset_rel", e_reset, 1);
        check("adclk_1",     adclk, 1);
        check("clk_32_1",    clk_32, 0);
        check("e_mdc",       e_mdc, 0);
        check("e_txer",      gmii.e_txer, 0);
`ifdef DAC_LOOPBACK_EN
        check("dac_1", dadata, 8'h08);
`else
        check("dac_1", dadata, 8'd1);
`endif
        repeat (5) @(negedge clk);
        check("adclk_6",  adclk, 0);
        check("clk_32_6", clk_32, 1);
`ifdef DAC_LOOPBACK_EN
        check("dac_6", dadata, 8'h08);
`else
        check("dac_6", dadata, 8'd3);
`endif

        // too-short press
        b0 = n_begin;
        press(3);
        repeat (10) @(negedge clk);
        check("short_press_begin", n_begin - b0, 0);
        check("short_press_state", current_state, 0);

        // frame 1, payload 8'h08
        b0 = n_begin; r0 = n_ovrst; f0 = n_fiforst; e0 = n_ovre; t0 = n_ovtx;
        push_frame(8'h08);
        press(10);
        check("begin_pulse", n_begin - b0, 1);
        check("state_fifo_rst", current_state, 1);
        wait_state(4'd2, 600, "enter_record");
        check("fifo_rst_cycles", n_fiforst - f0, 512);
        check("overrst_pulse",   n_ovrst - r0, 1);
        check("rst_cnt_max",     max_rst_cnt, 511);
        check("enadc_record",    enADC, 1);
        wait_state(4'd3, 2600, "enter_tx_pre");
        check("count_full",    fifo_data_count, 1024);
        check("overre_pulse",  n_ovre - e0, 1);
        wait_state(4'd4, 20, "enter_tx_data");
        press(10);                        // ignored while transmitting
        wait_state(4'd5, 1100, "enter_done");
        wait_state(4'd0, 5, "back_idle_1");
        check("temp_led_1",   temp_led, 1);
        check("count_empty",  fifo_data_count, 0);
        check("overtx_pulse", n_ovtx - t0, 1);
        repeat (20) @(negedge clk);
        check("tx_press_ignored", current_state, 0);
        check("frames_1", frames_done, 1);

        // frame 2, payload 8'h3C
        addata = 8'h3C;
        push_frame(8'h3C);
        press(10);
        wait_state(4'd5, 4000, "frame2_done");
        wait_state(4'd0, 5, "back_idle_2");
        check("temp_led_2", temp_led, 0);
        repeat (20) @(negedge clk);
        check("frames_2", frames_done, 2);

        // reset in the middle of recording
        addata = 8'hA5;
        press(10);
        wait_state(4'd2, 600, "record_3");
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_state", current_state, 0);
        check("midrst_count", fifo_data_count, 0);
        check("midrst_txen",  gmii.e_txen, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_state", current_state, 0);
        check("frames_final",   frames_done, 2);
        check("queue_drained",  exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
